// File: rtl/register_file_mw_mr_be_latch.sv
// Latch-based register file: N_WRITE write ports, N_READ read ports, per-byte
// write enables, arbitrary depth. Each (write port, word, byte) owns an
// integrated clock gate, modelled here as the tc_clk_gating structure (enable
// latch transparent while the clock is low, ANDed with the clock). An optional
// sequencer zeroes the array after reset because the storage latches have none.
module register_file_mw_mr_be_latch #(
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned N_WRITE    = 2,
    parameter bit          INIT_ZERO  = 1'b1,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  test_en_i,
    output logic                                  init_done_o,
    input  logic [N_READ-1:0]                     ReadEnable,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
    output logic [N_READ-1:0][DATA_WIDTH-1:0]     ReadData,
    output logic [N_READ-1:0]                     ReadValid,
    input  logic [N_WRITE-1:0]                    WriteEnable,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    WriteAddr,
    input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    WriteData,
    input  logic [N_WRITE-1:0][NUM_BYTES-1:0]     WriteBE
);

    localparam logic [0:0]          ST_INIT   = 1'b0;
    localparam logic [0:0]          ST_RUN    = 1'b1;
    localparam logic [0:0]          ST_RESET  = INIT_ZERO ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH:0] LP_WORDS  = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [0:0]                                r_state;
    logic [ADDR_WIDTH-1:0]                     r_cnt;
    logic                                      r_init_done;
    logic [N_READ-1:0]                         r_rvalid;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]         r_raddr;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0]        r_wdata;

    logic                                      w_run_acc;
    logic                                      w_init_wr;
    logic                                      w_gate_en;
    logic                                      r_gate_lat;
    logic                                      w_clk_global;
    logic [N_WRITE-1:0][NUM_WORDS-1:0][NUM_BYTES-1:0] w_en;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]      w_mem;

    // Port requests only count once the array is initialised and reset is released;
    // the zeroing sequencer writes one word per edge while in INIT.
    assign w_run_acc   = rst_n & r_init_done;
    assign w_init_wr   = rst_n & (r_state == ST_INIT);
    assign init_done_o = r_init_done;
    assign ReadValid   = r_rvalid;

    // FSM, init counter, read address capture and write data sampling.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rvalid    <= '0;
            r_raddr     <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt      <= r_cnt + ADDR_WIDTH'(1);
                    r_wdata[0] <= '0;
                    if (r_cnt == LP_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN:  r_init_done <= 1'b1;
                default: r_state <= ST_RESET;
            endcase
            for (int p = 0; p < int'(N_READ); p++) begin
                r_rvalid[p] <= r_init_done & ReadEnable[p];
                if (r_init_done && ReadEnable[p]) r_raddr[p] <= ReadAddr[p];
            end
            for (int q = 0; q < int'(N_WRITE); q++) begin
                if (r_init_done && WriteEnable[q] && ({1'b0, WriteAddr[q]} < LP_WORDS))
                    r_wdata[q] <= WriteData[q];
            end
        end
    end

    // Write decoder: per word-byte, the highest-index requesting port keeps its enable.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin : p_decode
        logic v_taken;
        logic v_hit;
        w_en    = '0;
        v_taken = 1'b0;
        v_hit   = 1'b0;
        for (int w = 0; w < int'(NUM_WORDS); w++) begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                v_taken = 1'b0;
                for (int q = int'(N_WRITE) - 1; q >= 0; q--) begin
                    v_hit = (w_run_acc && WriteEnable[q] && WriteBE[q][b] &&
                             (WriteAddr[q] == ADDR_WIDTH'(w))) ||
                            ((q == 0) && w_init_wr && (r_cnt == ADDR_WIDTH'(w)));
                    if (v_hit && !v_taken) begin
                        w_en[q][w][b] = 1'b1;
                        v_taken       = 1'b1;
                    end
                end
            end
        end
    end

    assign w_gate_en = (|WriteEnable) | (r_state == ST_INIT);

    // Global clock gate enable latch, transparent while clk is low; scan forces it open.
    always_latch begin
        if (!clk) r_gate_lat <= w_gate_en | test_en_i;
    end
    assign w_clk_global = clk & r_gate_lat;

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
            logic [N_WRITE-1:0] w_port_clk;
            logic               w_byte_clk;
            logic [7:0]         w_din;
            logic [7:0]         r_data;

            for (genvar q = 0; q < N_WRITE; q++) begin : g_port
                logic r_en_lat;
                // Per port/word/byte gate enable latch (test enable tied off).
                always_latch begin
                    if (!w_clk_global) r_en_lat <= w_en[q][w][b];
                end
                assign w_port_clk[q] = w_clk_global & r_en_lat;
            end

            assign w_byte_clk = |w_port_clk;

            // Latch input chosen by whichever port clock is active (one-hot by construction).
            always_comb begin
                w_din = '0;
                for (int q = 0; q < int'(N_WRITE); q++) begin
                    if (w_port_clk[q]) w_din = r_wdata[q][8*b +: 8];
                end
            end

            // Storage byte, transparent during the high phase of its gated clock.
            // NOTE: storage latches carry no reset; the INIT sequencer zeroes them instead.
            always_latch begin
                if (w_byte_clk) r_data <= w_din;
            end

            assign w_mem[w][8*b +: 8] = r_data;
        end
    end

    // Read mux through the registered address; zero before init and for out-of-range words.
    always_comb begin
        ReadData = '0;
        for (int p = 0; p < int'(N_READ); p++) begin
            if (r_init_done && ({1'b0, r_raddr[p]} < LP_WORDS)) ReadData[p] = w_mem[r_raddr[p]];
        end
    end

endmodule

// File: doc/register_file_mw_mr_be_latch.md
Name: register_file_mw_mr_be_latch

Overview:
- Latch-based standard-cell register file with N_WRITE write ports, N_READ read ports, per-byte write enables and arbitrary (non-power-of-2) depth.
- Adds an optional post-reset zero-initialisation sequencer, since latches have no reset.
- Sits beside the existing single-write SCM macros; targets multi-issue register files and small per-core buffers in cluster designs.
- Storage is latches clocked by per-port, per-word, per-byte tc_clk_gating cells.

Parameters:
NUM_WORDS, 32, number of words; any value >= 2
DATA_WIDTH, 32, word width; multiple of 8
N_READ, 2, read ports
N_WRITE, 2, write ports
INIT_ZERO, 1, 1 = run zero-init sequence after reset; 0 = skip
ADDR_WIDTH, $clog2(NUM_WORDS), derived address width (localparam, not overridable)
NUM_BYTES, DATA_WIDTH/8, derived byte lanes (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
test_en_i  in  1  forces global gate transparent in scan test
init_done_o  out  1  high when array initialised and requests are accepted
ReadEnable  in  N_READ  per-port read request
ReadAddr  in  N_READ x ADDR_WIDTH  read addresses
ReadData  out  N_READ x DATA_WIDTH  read data
ReadValid  out  N_READ  ReadData[p] holds a valid read result
WriteEnable  in  N_WRITE  per-port write request
WriteAddr  in  N_WRITE x ADDR_WIDTH  write addresses
WriteData  in  N_WRITE x DATA_WIDTH  write data
WriteBE  in  N_WRITE x NUM_BYTES  byte enables, bit b covers bits 8b+7:8b

Behaviour:
- Reset is synchronous, active-low, on clk: rst_n low sampled at a rising edge gives state INIT (or RUN when INIT_ZERO=0), init counter=0, init_done_o=0, ReadValid=0, read address regs=0, sampled write data regs=0. Latch contents are not reset.
- FSM states are INIT and RUN.
- INIT: at each edge an internal write of all-zero data, all bytes enabled, to word cnt; cnt increments.
  - On the edge where cnt==NUM_WORDS-1, go to RUN and register init_done_o<=1.
  - init_done_o therefore rises after the NUM_WORDS-th edge with rst_n high.
  - Port requests (ReadEnable, WriteEnable) are ignored while init_done_o==0.
- INIT_ZERO=0: go to RUN at the first edge with rst_n high; init_done_o=1 from then on.
- Reset asserted mid-INIT or mid-RUN: on that edge return to the reset state; INIT restarts from word 0.
- Reads, RUN, 1-cycle latency: if ReadEnable[p] is high at edge E, register ReadAddr[p].
  - ReadData[p] is combinational from the latch array via the registered address, stable during cycle E..E+1.
  - ReadValid[p]<=1 at E.
  - ReadEnable[p] low at E: address reg holds, ReadValid[p]<=0, ReadData[p] keeps showing the last addressed word.
- ReadData[p] is forced to 0 while init_done_o==0.
- Read address >= NUM_WORDS: ReadData[p]=0, ReadValid[p] still 1.
- Writes, RUN: at edge E, for each port q with WriteEnable[q] high and WriteAddr[q] < NUM_WORDS:
  - WriteData[q] is sampled into a per-port data reg.
  - The decoder enables the gated clock for each (q, word, byte) with WriteBE[q][b]=1.
  - The latch is transparent in the high phase after E; the new value is stable before E+1.
  - Out-of-range write address: dropped.
  - WriteBE all zero: no change.
- Write collision, same word and same byte from several ports at one edge: highest-index port wins that byte. Losing ports' enables are suppressed in the decoder before the ICGs, so at most one port clock per word-byte is active.
  - Example: ports 0 and 1 hit word 5 with BE 4'b1111 and 4'b0011 → bytes 1:0 from port 1, bytes 3:2 from port 0.
- Read/write same word, same edge: ReadData during the following cycle shows the newly written bytes once the latch is transparent, settled before the next edge (write-through). Unwritten bytes keep their old value.
- Per-word latch input is selected by the active port clock (one-hot).
- Global write gate: one tc_clk_gating enabled by OR of WriteEnable or INIT, test_en_i wired. Per-word-byte ICGs: test_en_i tied 0.

Test Plan:
- INIT_ZERO=1, NUM_WORDS=24: release reset → init_done_o rises after edge 24; read every word → 0, ReadValid=1; reads and writes issued before init_done_o have no effect.
- Write port 0 word 7 = 0xDEADBEEF BE=4'hF; next cycle write port 1 word 7 = 0x00001234 BE=4'h3 → read word 7 returns 0xDEAD1234.
- Same edge: port 0 word 3 = 0xAAAAAAAA BE=F and port 1 word 3 = 0x55555555 BE=4'hC → word 3 = 0x5555AAAA. Simultaneous distinct addresses 1 and 2 both written correctly.
- Write word 9 = 0x0BADF00D and read word 9 on the same edge → ReadData = 0x0BADF00D in the next cycle. ReadEnable low afterwards → ReadValid=0 and ReadData unchanged.
- Write to address 30 (NUM_WORDS=24) → no word changes; read address 30 → ReadData=0.
- Assert rst_n for one cycle mid-INIT at cnt=10 → init_done_o=0, INIT restarts, rises 24 edges after release. Repeat with INIT_ZERO=0 → init_done_o high one edge after release.
